// File: rtl/fifo_uart_tx_if.sv
// ============================================================================
// fifo_uart_tx_if : pull handshake between the UART transmitter and its FIFO
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fifo_uart_tx_if;
    logic       fifoNotEmpty;
    logic       fifoRead;
    logic       fifoDataReady;
    logic [7:0] fifoData;

    // The transmitter drives the pull request.
    modport master (
        input  fifoNotEmpty,
        input  fifoDataReady,
        input  fifoData,
        output fifoRead
    );

    modport slave (
        output fifoNotEmpty,
        output fifoDataReady,
        output fifoData,
        input  fifoRead
    );
endinterface

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
// ============================================================================
// fifo_uart_tx : pulls bytes from a FIFO and sends them as 8N1 UART frames
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          enable,
    fifo_uart_tx_if.master     fifo,
    output logic               tx,
    output logic               busy,
    output logic               timeoutErr,
    output logic [15:0]        txCount
);

    localparam logic [15:0] c_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] c_WAIT_LAST = 16'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  sh_q;
    logic        tx_q;
    logic        busy_q;
    logic        rd_q;
    logic        tmo_q;
    logic [15:0] txcnt_q;
    logic        armed_q;

    assign tx            = tx_q;
    assign busy          = busy_q;
    assign timeoutErr    = tmo_q;
    assign txCount       = txcnt_q;
    assign fifo.fifoRead = rd_q;

    // armed_q keeps the first edge after reset release from issuing a pull.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            rd_q    <= 1'b0;
            tmo_q   <= 1'b0;
            txcnt_q <= '0;
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            rd_q    <= 1'b0;
            tmo_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (armed_q && enable && fifo.fifoNotEmpty) begin
                        rd_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // cnt_q counts unanswered WAIT cycles here.
                    if (fifo.fifoDataReady) begin
                        sh_q    <= fifo.fifoData;
                        tx_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_START;
                    end else if (cnt_q == c_WAIT_LAST) begin
                        tmo_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_START: begin
                    if (cnt_q == c_BIT_LAST) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        tx_q    <= sh_q[0];
                        state_q <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == c_BIT_LAST) begin
                        cnt_q <= '0;
                        if (idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                            tx_q  <= sh_q[1];
                            sh_q  <= {1'b0, sh_q[7:1]};
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == c_BIT_LAST) begin
                        cnt_q   <= '0;
                        txcnt_q <= txcnt_q + 16'd1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per UART bit; legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge only.
REQ-003 The block SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port enable, input, 1, which permits new FIFO pulls when high.
REQ-005 The block SHALL have port fifoNotEmpty, input, 1, high when the upstream FIFO holds at least one byte.
REQ-006 The block SHALL have port fifoRead, output, 1, a one-cycle pull request to the FIFO.
REQ-007 The block SHALL have port fifoDataReady, input, 1, the FIFO's one-cycle flag marking fifoData valid.
REQ-008 The block SHALL have port fifoData, input, 8, the byte returned by the FIFO.
REQ-009 The block SHALL have port tx, output, 1, the UART serial line; idle level is 1.
REQ-010 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 The block SHALL have port timeoutErr, output, 1, a one-cycle pulse when a pull is not answered.
REQ-012 The block SHALL have port txCount, output, 16, the number of frames completed.

Function
REQ-013 The state machine SHALL have states IDLE, WAIT, START, DATA and STOP; all outputs SHALL be registered.
REQ-014 IDLE: if enable and fifoNotEmpty are sampled high at an edge, fifoRead SHALL be 1 for exactly the next cycle and the state SHALL go to WAIT; otherwise fifoRead SHALL be 0.
REQ-015 WAIT: at each edge where fifoDataReady=1, fifoData SHALL be latched into an 8-bit shift register, the state SHALL go to START, and tx SHALL go to 0 from that edge.
REQ-016 WAIT timeout: after 4 consecutive WAIT cycles without fifoDataReady, timeoutErr SHALL pulse for 1 cycle, the state SHALL return to IDLE, and no frame SHALL be sent.
REQ-017 fifoDataReady outside WAIT SHALL be ignored, with no capture and no state change.
REQ-018 START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-019 DATA: 8 bits SHALL be sent LSB first, each held for exactly CLKS_PER_BIT cycles; a 3-bit index SHALL count 0..7, then go to STOP.
REQ-020 STOP: tx=1 for exactly CLKS_PER_BIT cycles; at the end txCount SHALL increment by 1 (mod 2^16, 0xFFFF wraps to 0x0000) and the state SHALL go to IDLE.
REQ-021 Frame length SHALL be 10*CLKS_PER_BIT cycles from the tx falling edge to the return to IDLE.
REQ-022 Back-to-back: if enable and fifoNotEmpty are high on the first IDLE cycle, fifoRead SHALL assert on the next cycle, so the inter-frame gap is 1 IDLE cycle + fifoRead cycle + FIFO response.
REQ-023 Deasserting enable mid-frame SHALL NOT abort the frame; it SHALL only block the next pull.
REQ-024 The bit-period counter SHALL be 16 bits wide, count 0..CLKS_PER_BIT-1, and clear on every state transition.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, tx=1, fifoRead=0, busy=0, timeoutErr=0, txCount=0, shift register=0, bit index=0 and the bit-period counter=0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no further tx toggles and no txCount increment.
REQ-027 After rst_n rises, the first fifoRead SHALL NOT occur before the second rising edge of clk.

Verification (CLKS_PER_BIT=4, FIFO model answers fifoDataReady 1 cycle after fifoRead)
REQ-028 Single byte 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles; busy high 40+ cycles; txCount=1.
REQ-029 Two bytes 0x00, 0xFF queued, enable=1 -> exactly two fifoRead pulses; frames 0,0x8,1 and 0,1x8,1; txCount=2.
REQ-030 fifoNotEmpty=0, enable=1 for 100 cycles -> fifoRead never asserts, tx=1, busy=0.
REQ-031 FIFO model never answers -> timeoutErr pulses once, 4 cycles after WAIT entry; tx stays 1; txCount unchanged; a new pull follows.
REQ-032 rst_n low during DATA bit 3 -> tx=1 asynchronously; txCount=0; after release with enable=0, busy=0.
REQ-033 enable dropped during START of 0x3C -> full 0x3C frame completes; no further fifoRead.
